// File: rtl/ws2812_pkg.sv
// Shared timing constants and state encoding for the WS2812 frame sequencer.
// All timing values are in 50 MHz clock cycles.
package ws2812_pkg;

    localparam int T0H          = 20;
    localparam int T1H          = 45;
    localparam int TBIT         = 64;
    localparam int TRESET       = 2500;
    localparam int MAX_LEDS     = 256;
    localparam int LW           = $clog2(MAX_LEDS + 1);
    localparam int BITS_PER_LED = 24;
    localparam int CW           = $clog2(TBIT);
    localparam int RW           = $clog2(TRESET);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        LATCH
    } state_t;

endpackage

// File: rtl/ws2812_bit_cell.sv
// One WS2812 bit cell: a load pulse starts a TBIT-cycle cell whose high time
// depends on bit_val. A load in the cell_end cycle chains cells with no gap.
module ws2812_bit_cell
    import ws2812_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic bit_val,
    output logic dout,
    output logic cell_end
);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] high_reg;
    logic [CW-1:0] cnt_inc;
    logic          active_reg;
    logic          dout_reg;

    assign cnt_inc  = cnt_reg + 1'b1;
    assign cell_end = active_reg && (cnt_reg == CW'(TBIT - 1));
    assign dout     = dout_reg;

    // dout is registered, so it is computed for the count value of the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            high_reg   <= '0;
            active_reg <= 1'b0;
            dout_reg   <= 1'b0;
        end else if (load) begin
            cnt_reg    <= '0;
            high_reg   <= bit_val ? CW'(T1H) : CW'(T0H);
            active_reg <= 1'b1;
            dout_reg   <= 1'b1;
        end else if (cell_end) begin
            cnt_reg    <= '0;
            active_reg <= 1'b0;
            dout_reg   <= 1'b0;
        end else if (active_reg) begin
            cnt_reg    <= cnt_inc;
            dout_reg   <= (cnt_inc < high_reg);
        end
    end

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Frame controller: fetches GRB pixels over valid/ready, shifts them MSB-first
// through the bit cell, then holds the line low for the latch period.
module ws2812_frame_sequencer
    import ws2812_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] num_leds,
    input  logic [23:0]   pix_data,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          dout,
    output logic          busy,
    output logic          done,
    output logic          underrun
);

    state_t        state_reg, state_next;
    logic [LW-1:0] num_reg, num_next;
    logic [LW-1:0] acc_reg, acc_next;
    logic [LW-1:0] sent_reg, sent_next;
    logic [23:0]   shift_reg, shift_next;
    logic [23:0]   hold_reg, hold_next;
    logic          hold_valid_reg, hold_valid_next;
    logic [4:0]    bit_reg, bit_next;
    logic [RW-1:0] lat_reg, lat_next;
    logic          underrun_reg, underrun_next;
    logic          load, load_bit, cell_end, accept;

    assign pix_ready = (state_reg == FETCH) ||
                       ((state_reg == SEND) && !hold_valid_reg && (acc_reg < num_reg));
    assign accept    = pix_ready && pix_valid;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == LATCH) && (lat_reg == RW'(TRESET - 1));
    assign underrun  = underrun_reg;

    ws2812_bit_cell u_cell (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .bit_val  (load_bit),
        .dout     (dout),
        .cell_end (cell_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            num_reg        <= '0;
            acc_reg        <= '0;
            sent_reg       <= '0;
            shift_reg      <= '0;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            bit_reg        <= '0;
            lat_reg        <= '0;
            underrun_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            num_reg        <= num_next;
            acc_reg        <= acc_next;
            sent_reg       <= sent_next;
            shift_reg      <= shift_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            bit_reg        <= bit_next;
            lat_reg        <= lat_next;
            underrun_reg   <= underrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        num_next        = num_reg;
        acc_next        = acc_reg;
        sent_next       = sent_reg;
        shift_next      = shift_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        bit_next        = bit_reg;
        lat_next        = lat_reg;
        underrun_next   = 1'b0;
        load            = 1'b0;
        load_bit        = shift_reg[23];

        unique case (state_reg)
            IDLE: begin
                if (start && (num_leds != '0)) begin
                    state_next      = FETCH;
                    num_next        = num_leds;
                    acc_next        = '0;
                    sent_next       = '0;
                    hold_valid_next = 1'b0;
                end
            end
            FETCH: begin
                if (pix_valid) begin
                    shift_next = pix_data;
                    bit_next   = 5'(BITS_PER_LED - 1);
                    acc_next   = LW'(1);
                    sent_next  = LW'(1);
                    load       = 1'b1;
                    load_bit   = pix_data[23];
                    state_next = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    hold_next       = pix_data;
                    hold_valid_next = 1'b1;
                    acc_next        = acc_reg + 1'b1;
                end
                if (cell_end) begin
                    if (bit_reg != 5'd0) begin
                        shift_next = {shift_reg[22:0], 1'b0};
                        bit_next   = bit_reg - 1'b1;
                        load       = 1'b1;
                        load_bit   = shift_reg[22];
                    end else if (sent_reg == num_reg) begin
                        state_next = LATCH;
                        lat_next   = '0;
                    end else if (hold_valid_reg) begin
                        // Next pixel starts in the very next cycle; hold frees up
                        // unless a new pixel lands in it on this same edge.
                        shift_next = hold_reg;
                        bit_next   = 5'(BITS_PER_LED - 1);
                        sent_next  = sent_reg + 1'b1;
                        load       = 1'b1;
                        load_bit   = hold_reg[23];
                        if (!accept) begin
                            hold_valid_next = 1'b0;
                        end
                    end else begin
                        underrun_next = 1'b1;
                        state_next    = LATCH;
                        lat_next      = '0;
                    end
                end
            end
            LATCH: begin
                if (lat_reg == RW'(TRESET - 1)) begin
                    state_next = IDLE;
                    lat_next   = '0;
                end else begin
                    lat_next = lat_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/ws2812_frame_sequencer.md
# ws2812_frame_sequencer

Frame-level controller for the WS2812 LED chain on the 50 MHz board clock. Per frame it accepts a LED count, pulls 24-bit GRB pixels from an upstream source over a valid/ready handshake, and serialises them MSB-first as WS2812 bit cells. It closes each frame with the ≥50 µs low latch period and reports completion. It sits between the pixel buffer/pattern generator and the chain's data pin, and sequences the single-bit encoder timing.

## Interface
- T0H, 20, high cycles for a 0 bit (0.40 µs)
- T1H, 45, high cycles for a 1 bit (0.90 µs)
- TBIT, 64, total cycles per bit cell (1.28 µs); must exceed T1H
- TRESET, 2500, low cycles of the latch period (50 µs)
- MAX_LEDS, 256, largest chain length; LW = clog2(MAX_LEDS+1)
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle frame request, sampled only in IDLE
- num_leds  in  LW  pixels in this frame, sampled with start
- pix_data  in  24  GRB pixel, G[23:16] R[15:8] B[7:0]
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  sequencer accepts pix_data this cycle
- dout  out  1  registered serial line to the LED chain
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at end of latch period
- underrun  out  1  one-cycle pulse when the next pixel is missing at a pixel boundary

## Operation
- States: IDLE, FETCH, SEND, LATCH.
- IDLE: start=1 and num_leds>0 latches num_leds and goes to FETCH. If num_leds=0, start is ignored with no done. start outside IDLE is ignored.
- FETCH: pix_ready=1. On pix_valid&pix_ready, the pixel loads into the 24-bit shift register, bit counter = 23, and the state goes to SEND. FETCH waits indefinitely, with dout=0, for the first pixel only.
- One-entry holding register. pix_ready is high in FETCH, or in SEND when hold is empty and the accepted count is less than num_leds.
- SEND: each bit cell is TBIT cycles. dout=1 for the first T1H cycles if the shift MSB is 1, otherwise the first T0H cycles; dout=0 for the rest of the cell. After cell end the register shifts left and the bit counter decrements.
- End of bit 0 of a pixel:
  - If sent == num_leds, go to LATCH.
  - Else if hold is valid, transfer hold to the shift register and the next cell starts the next cycle. There is no gap.
  - Else pulse underrun, abort the remaining pixels, and go to LATCH.
- LATCH: dout=0 for TRESET cycles, pulse done in the last cycle, then go to IDLE.
- Hold transfer and a new pix_valid&pix_ready in the same cycle are both honoured: hold receives the new pixel.
- The accepted count never exceeds num_leds. Excess upstream pixels are not consumed.

## Timing
- Reset values: state IDLE, dout=0, pix_ready=0, busy=0, done=0, underrun=0, hold empty, counters 0.
- rst mid-frame: all of the above immediately (async). The frame is lost, and no done or underrun pulse is issued.
- start at edge k: busy=1 and pix_ready=1 from cycle k+1.
- First pixel accepted at edge n: dout rises in cycle n+1.
- Consecutive cells and pixels are back-to-back: each rising edge of dout is exactly TBIT cycles after the previous one.
- Frame length from first dout rise to done = 24·num_leds·TBIT + TRESET cycles.
- busy stays high through the done cycle and drops the cycle after.
- underrun pulses in the cycle LATCH is entered.

## Structure
- ws2812_pkg: T0H/T1H/TBIT/TRESET defaults, BITS_PER_LED=24, state enum.
- Sub-module ws2812_bit_cell: given bit value and a load pulse, counts TBIT cycles, drives dout, and emits cell_end. The FSM, hold register, and pixel counters live in the top.

## Test plan
- num_leds=1, pixel 0xFF0000 presented before start → 8 highs of 45 cycles, then 16 highs of 20 cycles, each TBIT=64 apart, then 2500 low cycles, done pulse, busy low.
- num_leds=3, pix_valid held high, pixels 0x000001/0x800000/0xAAAAAA → rising edges exactly 64 cycles apart for 72 cells, 3 handshakes, and no 4th accept.
- num_leds=2, second pixel withheld past end of pixel 0 → underrun pulse at the boundary, dout low 2500 cycles, then done.
- rst asserted mid-cell of pixel 1 → dout, busy, and pix_ready are 0 the same cycle. A new start afterwards runs a clean frame.
- start with num_leds=0 → no busy, no done. start pulsed during SEND → frame length unchanged.
- First pixel delayed 100 cycles after start → dout stays 0, then the frame proceeds normally.
